// File: rtl/bitcoin_nonce_search.sv
// Double SHA-256 nonce sweep over a 19-word header prefix held in shared memory.
// Define TARGET_CMP_EN to stop at the first H0 below target and report that nonce.
module bitcoin_nonce_search #(
   parameter int          NUM_NONCES = 16,
   parameter logic [31:0] NONCE_BASE = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] message_addr,
   input  logic [15:0] output_addr,
   input  logic [31:0] target,
   output logic        done,
   output logic        found,
   output logic [31:0] found_nonce,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);
   typedef enum logic [3:0] {
      S_IDLE, S_READ, S_BLK1, S_ADD1, S_BLK2, S_ADD2, S_BLK3, S_ADD3, S_WRITE, S_DONE
   } state_t;

   localparam logic [15:0] LP_NUM = 16'(NUM_NONCES);

   localparam logic [31:0] LP_K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [31:0] LP_IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] f_rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   state_t      r_state, w_next;
   logic [5:0]  r_cnt, w_rd_idx;
   logic [15:0] r_idx;
   logic [31:0] r_nonce, r_h0, w_blk2_nonce, w_t1, w_t2, w_wnew;
   logic [31:0] r_w [16];
   logic [31:0] r_v [8];
   logic [31:0] r_mid [8];
   logic [31:0] r_tail [3];
   logic [31:0] w_blk2 [16];
   logic [31:0] w_sum_iv [8];
   logic [31:0] w_sum_mid [8];
   logic        r_done, w_stop;

   assign mem_clk = clk;
   assign done    = r_done;

`ifdef TARGET_CMP_EN
   logic        r_found;
   logic [31:0] r_found_nonce;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_found       <= 1'b0;
         r_found_nonce <= '0;
      end else if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
         r_found       <= 1'b0;
         r_found_nonce <= '0;
      end else if (r_state == S_ADD3 && w_sum_iv[0] < target) begin
         r_found       <= 1'b1;
         r_found_nonce <= r_nonce;
      end
   end

   assign found       = r_found;
   assign found_nonce = r_found_nonce;
   assign w_stop      = r_found;
`else
   logic w_unused_target;
   assign w_unused_target = ^target;
   assign found           = 1'b0;
   assign found_nonce     = '0;
   assign w_stop          = 1'b0;
`endif

   // One SHA-256 round plus the next schedule word from the 16-word window.
   always_comb begin
      w_t1 = r_v[7] + (f_rotr(r_v[4], 6) ^ f_rotr(r_v[4], 11) ^ f_rotr(r_v[4], 25))
           + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + LP_K[r_cnt] + r_w[0];
      w_t2 = (f_rotr(r_v[0], 2) ^ f_rotr(r_v[0], 13) ^ f_rotr(r_v[0], 22))
           + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
      w_wnew = (f_rotr(r_w[14], 17) ^ f_rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
             + (f_rotr(r_w[1], 7) ^ f_rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];
      w_rd_idx = r_cnt - 6'd1;
      // WRITE preloads the following nonce's second block.
      w_blk2_nonce = (r_state == S_WRITE) ? r_nonce + 32'd1 : r_nonce;
      for (int unsigned k = 0; k < 16; k++) w_blk2[k] = '0;
      w_blk2[0]  = r_tail[0];
      w_blk2[1]  = r_tail[1];
      w_blk2[2]  = r_tail[2];
      w_blk2[3]  = w_blk2_nonce;
      w_blk2[4]  = 32'h80000000;
      w_blk2[15] = 32'd640;
      for (int unsigned k = 0; k < 8; k++) begin
         w_sum_iv[k]  = LP_IV[k] + r_v[k];
         w_sum_mid[k] = r_mid[k] + r_v[k];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_READ;
         S_READ: begin
            if (r_cnt < 6'd19) mem_addr = message_addr + {10'd0, r_cnt};
            if (r_cnt == 6'd19) w_next = S_BLK1;
         end
         S_BLK1: if (r_cnt == 6'd63) w_next = S_ADD1;
         S_ADD1: w_next = S_BLK2;
         S_BLK2: if (r_cnt == 6'd63) w_next = S_ADD2;
         S_ADD2: w_next = S_BLK3;
         S_BLK3: if (r_cnt == 6'd63) w_next = S_ADD3;
         S_ADD3: w_next = S_WRITE;
         S_WRITE: begin
            mem_we         = 1'b1;
            mem_addr       = output_addr + r_idx;
            mem_write_data = r_h0;
            w_next         = (r_idx + 16'd1 == LP_NUM || w_stop) ? S_DONE : S_BLK2;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_nonce <= '0;
         r_h0    <= '0;
         r_done  <= 1'b0;
         for (int unsigned k = 0; k < 16; k++) r_w[k] <= '0;
         for (int unsigned k = 0; k < 8; k++) begin
            r_v[k]   <= '0;
            r_mid[k] <= '0;
         end
         for (int unsigned k = 0; k < 3; k++) r_tail[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_nonce <= NONCE_BASE;
                  r_done  <= 1'b0;
               end else if (r_state == S_DONE) begin
                  r_done <= 1'b1;
               end
            end
            S_READ: begin
               r_cnt <= (r_cnt == 6'd19) ? '0 : r_cnt + 6'd1;
               for (int unsigned k = 0; k < 8; k++) r_v[k] <= LP_IV[k];
               // Data for the address issued last cycle is on the bus now.
               if (r_cnt != '0) begin
                  if (w_rd_idx < 6'd16) begin
                     for (int unsigned k = 0; k < 15; k++) r_w[k] <= r_w[k+1];
                     r_w[15] <= mem_read_data;
                  end else begin
                     r_tail[w_rd_idx[1:0]] <= mem_read_data;
                  end
               end
            end
            S_BLK1, S_BLK2, S_BLK3: begin
               r_cnt  <= r_cnt + 6'd1;
               r_v[0] <= w_t1 + w_t2;
               r_v[1] <= r_v[0];
               r_v[2] <= r_v[1];
               r_v[3] <= r_v[2];
               r_v[4] <= r_v[3] + w_t1;
               r_v[5] <= r_v[4];
               r_v[6] <= r_v[5];
               r_v[7] <= r_v[6];
               for (int unsigned k = 0; k < 15; k++) r_w[k] <= r_w[k+1];
               r_w[15] <= w_wnew;
            end
            S_ADD1: begin
               for (int unsigned k = 0; k < 8; k++) begin
                  r_mid[k] <= w_sum_iv[k];
                  r_v[k]   <= w_sum_iv[k];
               end
               for (int unsigned k = 0; k < 16; k++) r_w[k] <= w_blk2[k];
            end
            S_ADD2: begin
               for (int unsigned k = 0; k < 8; k++) begin
                  r_w[k] <= w_sum_mid[k];
                  r_v[k] <= LP_IV[k];
               end
               r_w[8] <= 32'h80000000;
               for (int unsigned k = 9; k < 15; k++) r_w[k] <= '0;
               r_w[15] <= 32'd256;
            end
            S_ADD3: r_h0 <= w_sum_iv[0];
            S_WRITE: begin
               r_idx   <= r_idx + 16'd1;
               r_nonce <= r_nonce + 32'd1;
               for (int unsigned k = 0; k < 8; k++) r_v[k] <= r_mid[k];
               for (int unsigned k = 0; k < 16; k++) r_w[k] <= w_blk2[k];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bitcoin_nonce_search.sv
// Bench for bitcoin_nonce_search: random headers checked against a software double SHA-256.
module tb_bitcoin_nonce_search;
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start16 = 1'b0, start1 = 1'b0;
   logic [15:0] message_addr = '0, output_addr = '0;
   logic [31:0] target = '0;
   logic        done16, found16, mclk16, we16;
   logic        done1, found1, mclk1, we1;
   logic [31:0] fn16, wd16, rd16, fn1, wd1, rd1;
   logic [15:0] ma16, ma1;

   logic [31:0] mem [65536];
   logic [31:0] hdr [19];
   logic [31:0] exp16 [16];
   logic [31:0] saved [16];
   logic [15:0] q_a16 [$], q_a1 [$];
   logic [31:0] q_d16 [$], q_d1 [$];
   int checks = 0, errors = 0, cyc = 0;

   localparam logic [31:0] LK [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IV_P = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   bitcoin_nonce_search #(.NUM_NONCES(16), .NONCE_BASE(32'h0)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .message_addr(message_addr),
      .output_addr(output_addr), .target(target), .done(done16), .found(found16),
      .found_nonce(fn16), .mem_clk(mclk16), .mem_we(we16), .mem_addr(ma16),
      .mem_write_data(wd16), .mem_read_data(rd16));

   bitcoin_nonce_search #(.NUM_NONCES(1), .NONCE_BASE(32'hFFFFFFFF)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .message_addr(message_addr),
      .output_addr(output_addr), .target(target), .done(done1), .found(found1),
      .found_nonce(fn1), .mem_clk(mclk1), .mem_we(we1), .mem_addr(ma1),
      .mem_write_data(wd1), .mem_read_data(rd1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      rd16 <= mem[ma16];
      rd1  <= mem[ma1];
   end

   always @(negedge clk) begin
      if (we16 === 1'b1) begin q_a16.push_back(ma16); q_d16.push_back(wd16); end
      if (we1 === 1'b1) begin q_a1.push_back(ma1); q_d1.push_back(wd1); end
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 compression with a full 64-word schedule.
   function automatic logic [255:0] f_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] hout;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int k = 0; k < 8; k++) v[k] = hin[255 - 32*k -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + LK[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int k = 0; k < 8; k++) hout[255 - 32*k -: 32] = hin[255 - 32*k -: 32] + v[k];
      return hout;
   endfunction

   function automatic logic [31:0] f_h0(input logic [31:0] nonce);
      logic [511:0] b;
      logic [255:0] mid, d1, h;
      for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = hdr[j];
      mid = f_compress(IV_P, b);
      b   = {hdr[16], hdr[17], hdr[18], nonce, 32'h80000000, 320'd0, 32'd640};
      d1  = f_compress(mid, b);
      b   = {d1, 32'h80000000, 192'd0, 32'd256};
      h   = f_compress(IV_P, b);
      return h[255:224];
   endfunction

   task automatic load_header();
      message_addr = 16'($urandom);
      output_addr  = 16'($urandom);
      for (int j = 0; j < 19; j++) begin
         hdr[j] = $urandom;
         mem[16'(message_addr + 16'(j))] = hdr[j];
      end
   endtask

   // Pulse start on one engine and count cycles to done; lat = -1 if it never arrives.
   task automatic run(input int which, input int glitch_at, output int lat, output logic d0);
      int c0;
      if (which == 0) begin q_a16.delete(); q_d16.delete(); end
      else begin q_a1.delete(); q_d1.delete(); end
      @(negedge clk);
      if (which == 0) start16 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; start1 = 1'b0;
      c0  = cyc;
      d0  = (which == 0) ? done16 : done1;
      lat = -1;
      for (int n = 1; n <= 4000; n++) begin
         @(negedge clk);
         if (n == glitch_at) begin
            if (which == 0) start16 = 1'b1; else start1 = 1'b1;
         end else begin
            start16 = 1'b0; start1 = 1'b0;
         end
         if (((which == 0) ? done16 : done1) === 1'b1) begin
            lat = cyc - c0;
            break;
         end
      end
      start16 = 1'b0; start1 = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #1;
      checks++; if ({done16, found16, we16} !== 3'b000) begin errors++; $display("FAIL reset_flags16 got %b want 000", {done16, found16, we16}); end
      checks++; if ({fn16, ma16, wd16} !== 80'd0) begin errors++; $display("FAIL reset_buses16 got %h want 0", {fn16, ma16, wd16}); end
      checks++; if ({done1, found1, we1, fn1, ma1, wd1} !== 83'd0) begin errors++; $display("FAIL reset_all1 got %h want 0", {done1, found1, we1, fn1, ma1, wd1}); end
      repeat (3) @(negedge clk);
      checks++; if (mclk16 !== clk || mclk1 !== clk) begin errors++; $display("FAIL mem_clk got %b%b want %b", mclk16, mclk1, clk); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_nonce_wrap();
      int lat;
      logic d0;
      load_header();
      target = 32'h0;
      run(1, 0, lat, d0);
      checks++; if (lat != 217) begin errors++; $display("FAIL single_latency got %0d want 217", lat); end
      checks++; if (q_a1.size() != 1) begin errors++; $display("FAIL single_writes got %0d want 1", q_a1.size()); end
      if (q_a1.size() > 0) begin
         checks++; if (q_a1[0] !== output_addr) begin errors++; $display("FAIL single_addr got %h want %h", q_a1[0], output_addr); end
         checks++; if (q_d1[0] !== f_h0(32'hFFFFFFFF)) begin errors++; $display("FAIL single_h0 got %h want %h", q_d1[0], f_h0(32'hFFFFFFFF)); end
      end
      checks++; if (found1 !== 1'b0) begin errors++; $display("FAIL single_found got %b want 0", found1); end
   endtask

   task automatic test_reset_mid_blk2();
      load_header();
      q_a16.delete(); q_d16.delete();
      @(negedge clk);
      start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (150) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({done16, found16, we16, fn16, ma16, wd16} !== 83'd0) begin errors++; $display("FAIL midrst_outputs16 got %h want 0", {done16, found16, we16, fn16, ma16, wd16}); end
      checks++; if ({done1, found1, we1} !== 3'b000) begin errors++; $display("FAIL midrst_done1 got %b want 000", {done1, found1, we1}); end
      repeat (200) @(negedge clk);
      checks++; if (q_a16.size() != 0) begin errors++; $display("FAIL midrst_writes got %0d want 0", q_a16.size()); end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL midrst_idle_done got %b want 0", done16); end
   endtask

   task automatic test_multi_nonce();
      int lat;
      logic d0;
      load_header();
      target = 32'h0;
      for (int k = 0; k < 16; k++) exp16[k] = f_h0(32'(k));
      run(0, 0, lat, d0);
      checks++; if (lat != 2182) begin errors++; $display("FAIL multi_latency got %0d want 2182", lat); end
      checks++; if (q_a16.size() != 16) begin errors++; $display("FAIL multi_writes got %0d want 16", q_a16.size()); end
      for (int k = 0; k < 16 && k < q_a16.size(); k++) begin
         checks++; if (q_a16[k] !== 16'(output_addr + 16'(k))) begin errors++; $display("FAIL multi_addr%0d got %h want %h", k, q_a16[k], 16'(output_addr + 16'(k))); end
         checks++; if (q_d16[k] !== exp16[k]) begin errors++; $display("FAIL multi_h0_%0d got %h want %h", k, q_d16[k], exp16[k]); end
      end
      repeat (5) @(negedge clk);
      checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL multi_done_hold got %b want 1", done16); end
      checks++; if (q_a16.size() != 16) begin errors++; $display("FAIL multi_extra_writes got %0d want 16", q_a16.size()); end
   endtask

   task automatic test_start_ignored();
      int lat;
      logic d0;
      load_header();
      target = 32'h0;
      for (int k = 0; k < 16; k++) exp16[k] = f_h0(32'(k));
      run(0, 40, lat, d0);
      checks++; if (lat != 2182) begin errors++; $display("FAIL glitch_latency got %0d want 2182", lat); end
      checks++; if (q_a16.size() != 16) begin errors++; $display("FAIL glitch_writes got %0d want 16", q_a16.size()); end
      for (int k = 0; k < 16; k++) saved[k] = (k < q_a16.size()) ? q_d16[k] : 32'h0;
      run(0, 0, lat, d0);
      checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL rerun_done_clear got %b want 0", d0); end
      checks++; if (lat != 2182) begin errors++; $display("FAIL rerun_latency got %0d want 2182", lat); end
      checks++; if (q_a16.size() != 16) begin errors++; $display("FAIL rerun_writes got %0d want 16", q_a16.size()); end
      for (int k = 0; k < 16 && k < q_d16.size(); k++) begin
         checks++; if (q_d16[k] !== exp16[k] || saved[k] !== exp16[k]) begin errors++; $display("FAIL rerun_h0_%0d got %h/%h want %h", k, saved[k], q_d16[k], exp16[k]); end
      end
   endtask

`ifdef TARGET_CMP_EN
   task automatic test_target(input logic [31:0] tgt);
      int lat, hit, nw;
      logic d0;
      load_header();
      target = tgt;
      hit = -1;
      for (int k = 0; k < 16; k++) begin
         exp16[k] = f_h0(32'(k));
         if (hit < 0 && exp16[k] < tgt) hit = k;
      end
      nw = (hit < 0) ? 16 : hit + 1;
      run(0, 0, lat, d0);
      checks++; if (lat != 86 + 131 * nw) begin errors++; $display("FAIL target_latency got %0d want %0d", lat, 86 + 131 * nw); end
      checks++; if (q_a16.size() != nw) begin errors++; $display("FAIL target_writes got %0d want %0d", q_a16.size(), nw); end
      for (int k = 0; k < nw && k < q_d16.size(); k++) begin
         checks++; if (q_d16[k] !== exp16[k]) begin errors++; $display("FAIL target_h0_%0d got %h want %h", k, q_d16[k], exp16[k]); end
      end
      checks++; if (found16 !== (hit >= 0)) begin errors++; $display("FAIL target_found got %b want %b", found16, hit >= 0); end
      checks++; if (fn16 !== ((hit >= 0) ? 32'(hit) : 32'h0)) begin errors++; $display("FAIL target_nonce got %h want %h", fn16, (hit >= 0) ? 32'(hit) : 32'h0); end
   endtask
`else
   task automatic test_target_ignored();
      int lat;
      logic d0;
      load_header();
      target = 32'hFFFFFFFF;
      run(0, 0, lat, d0);
      checks++; if (lat != 2182) begin errors++; $display("FAIL tgt_ign_latency got %0d want 2182", lat); end
      checks++; if (q_a16.size() != 16) begin errors++; $display("FAIL tgt_ign_writes got %0d want 16", q_a16.size()); end
      checks++; if (found16 !== 1'b0 || fn16 !== 32'h0) begin errors++; $display("FAIL tgt_ign_found got %b/%h want 0/0", found16, fn16); end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_nonce_wrap();
      test_reset_mid_blk2();
      test_multi_nonce();
      test_start_ignored();
`ifdef TARGET_CMP_EN
      test_target(32'hFFFFFFFF);
      test_target(32'h0);
      test_target(32'h30000000);
`else
      test_target_ignored();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
